// File: rtl/quant_pkg.sv
`default_nettype none
// quant_pkg -- shared constants, command codes and per-channel parameter record for quant_pipe.
// Rev 1.0
package quant_pkg;

   localparam logic signed [31:0] INT32_MIN    = 32'sh8000_0000;
   localparam logic signed [31:0] INT32_MAX    = 32'sh7fff_ffff;
   localparam logic signed [63:0] ONE_SHIFT_30 = 64'sh0000_0000_4000_0000;
   localparam logic signed [63:0] ONE_SHIFT_31 = 64'sh0000_0000_8000_0000;

   typedef enum logic [6:0] {
      CMD_RST_CTR = 7'd0,
      CMD_BIAS    = 7'd1,
      CMD_MULT    = 7'd2,
      CMD_SHIFT   = 7'd3,
      CMD_ACT_MIN = 7'd4,
      CMD_ACT_MAX = 7'd5,
      CMD_OFFSET  = 7'd6,
      CMD_NUM_CH  = 7'd7,
      CMD_STATUS  = 7'd8
   } cmd_e;

   typedef struct packed {
      logic signed [31:0] bias;
      logic signed [31:0] mult;
      logic signed [31:0] shift;
   } chan_param_t;

endpackage
`default_nettype wire

// File: rtl/quant_lane.sv
`default_nettype none
// quant_lane -- one lane of requantization after the parameter read: shift/multiply,
// SRDHM, rounding right shift, offset and clamp, three register stages. Rev 1.0
module quant_lane
   import quant_pkg::*;
#(
   parameter int BYTE_SIZE = 8
) (
   input  logic                        clk,
   input  logic                        en,
   input  logic signed [31:0]          acc,
   input  chan_param_t                 param,
   input  logic signed [31:0]          out_offset,
   input  logic signed [31:0]          act_min,
   input  logic signed [31:0]          act_max,
   output logic        [BYTE_SIZE-1:0] q_out
);

   logic signed [31:0] biased, a;
   logic        [31:0] ls, rs;
   logic signed [63:0] ab;
   logic               sat;

   logic signed [63:0] ab_s2;
   logic        [31:0] rs_s2;
   logic               sat_s2;

   logic signed [63:0] nudge, sum;
   logic signed [31:0] sum_sh, r;
   logic               round_up;

   logic signed [31:0] r_s3;
   logic        [31:0] rs_s3;

   logic        [31:0] mask;
   logic signed [31:0] rem, thr, sra, q, y;

   always_comb begin
      biased = acc + param.bias;
      ls     = param.shift[31] ? 32'd0 : param.shift;
      rs     = param.shift[31] ? 32'(-param.shift) : 32'd0;
      a      = biased << ls;
      ab     = {{32{a[31]}}, a} * {{32{param.mult[31]}}, param.mult};
      sat    = (a == INT32_MIN) && (param.mult == INT32_MIN);
   end

   // Arithmetic shift floors; bump negative non-exact quotients to truncate toward zero.
   always_comb begin
      nudge    = (ab_s2 > 64'sd0) ? ONE_SHIFT_30 : (64'sd1 - ONE_SHIFT_30);
      sum      = ab_s2 + nudge;
      sum_sh   = 32'(sum >>> 31);
      round_up = sum[63] && ((sum & (ONE_SHIFT_31 - 64'sd1)) != 64'sd0);
      r        = sat_s2 ? INT32_MAX : (sum_sh + 32'(round_up));
   end

   always_comb begin
      mask = (32'd1 << rs_s3) - 32'd1;
      rem  = r_s3 & mask;
      thr  = (mask >> 1) + 32'(r_s3[31]);
      sra  = r_s3 >>> rs_s3;
      q    = sra + 32'(rem > thr);
      y    = q + out_offset;
      if (y < act_min) y = act_min;
      if (y > act_max) y = act_max;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         ab_s2  <= ab;
         rs_s2  <= rs;
         sat_s2 <= sat;
         r_s3   <= r;
         rs_s3  <= rs_s2;
         q_out  <= y[BYTE_SIZE-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/quant_pipe.sv
`default_nettype none
// quant_pipe -- multi-lane per-channel int32->int8 requantizer with CFU config port,
// banked parameter RAM, auto channel indexing and a stallable 4-stage pipeline. Rev 1.0
module quant_pipe
   import quant_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int MAX_CHANNELS = 256,
   parameter int INT32_SIZE   = 32,
   parameter int BYTE_SIZE    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [6:0]                    cmd,
   input  logic [31:0]                   inp0,
   input  logic [31:0]                   inp1,
   output logic [31:0]                   ret,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*INT32_SIZE-1:0]   in_acc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*BYTE_SIZE-1:0]    out_data
);

   localparam int DEPTH = MAX_CHANNELS / LANES;
   localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic               en, accept, busy, cfg_write;
   logic [3:0]         valid;
   logic [31:0]        chan_ctr, next_ctr, num_channels;
   logic signed [31:0] act_min, act_max, out_offset;
   logic [ROW_W-1:0]   rd_row, wr_row;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign accept    = in_valid && en;
   assign busy      = (|valid) || accept;
   assign cfg_write = !busy;
   assign out_valid = valid[3];
   assign next_ctr  = chan_ctr + 32'(LANES);
   // chan_ctr always steps by LANES from 0, so lane i of a beat always lands in bank i.
   assign rd_row    = ROW_W'(chan_ctr / 32'(LANES));
   assign wr_row    = ROW_W'(inp0 / 32'(LANES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid        <= '0;
         chan_ctr     <= '0;
         num_channels <= 32'(LANES);
         act_min      <= -32'sd128;
         act_max      <= 32'sd127;
         out_offset   <= '0;
         ret          <= '0;
      end else begin
         if (en) valid <= {valid[2:0], accept};

         if (cmd == CMD_RST_CTR)
            chan_ctr <= '0;
         else if (accept)
            chan_ctr <= (next_ctr >= num_channels) ? 32'd0 : next_ctr;

         case (cmd)
            CMD_RST_CTR: ret <= '0;
            CMD_BIAS, CMD_MULT, CMD_SHIFT: ;
            CMD_ACT_MIN: if (cfg_write) act_min      <= inp1;
            CMD_ACT_MAX: if (cfg_write) act_max      <= inp1;
            CMD_OFFSET:  if (cfg_write) out_offset   <= inp1;
            CMD_NUM_CH:  if (cfg_write) num_channels <= inp1;
            CMD_STATUS:  ret <= {busy, 15'b0, chan_ctr[15:0]};
            default:     ret <= '0;
         endcase
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [31:0] bias_mem  [DEPTH];
      logic signed [31:0] mult_mem  [DEPTH];
      logic signed [31:0] shift_mem [DEPTH];
      logic               bank_hit;
      logic signed [31:0] acc_s1;
      chan_param_t        param_s1;

      assign bank_hit = cfg_write && (inp0 < 32'(MAX_CHANNELS))
                        && ((inp0 % 32'(LANES)) == 32'(i));

      always_ff @(posedge clk) begin
         if (bank_hit && (cmd == CMD_BIAS))  bias_mem[wr_row]  <= inp1;
         if (bank_hit && (cmd == CMD_MULT))  mult_mem[wr_row]  <= inp1;
         if (bank_hit && (cmd == CMD_SHIFT)) shift_mem[wr_row] <= inp1;
         if (accept) begin
            acc_s1   <= in_acc[INT32_SIZE*i +: INT32_SIZE];
            param_s1 <= '{bias: bias_mem[rd_row], mult: mult_mem[rd_row], shift: shift_mem[rd_row]};
         end
      end

      quant_lane #(
         .BYTE_SIZE (BYTE_SIZE)
      ) u_lane (
         .clk        (clk),
         .en         (en),
         .acc        (acc_s1),
         .param      (param_s1),
         .out_offset (out_offset),
         .act_min    (act_min),
         .act_max    (act_max),
         .q_out      (out_data[BYTE_SIZE*i +: BYTE_SIZE])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_quant_pipe.sv
`default_nettype none
// tb_quant_pipe -- directed self-checking bench for quant_pipe.
module tb_quant_pipe;

   localparam logic [6:0]  IDLE  = 7'd9;
   localparam logic [31:0] M30   = 32'h4000_0000;
   localparam logic [31:0] MIN32 = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [6:0]   cmd = IDLE;
   logic [31:0]  inp0 = '0;
   logic [31:0]  inp1 = '0;
   logic [31:0]  ret;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_acc = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;

   int checks = 0;
   int errors = 0;

   quant_pipe #(
      .LANES        (4),
      .MAX_CHANNELS (256),
      .INT32_SIZE   (32),
      .BYTE_SIZE    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .inp0      (inp0),
      .inp1      (inp1),
      .ret       (ret),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
      cmd = c; inp0 = a; inp1 = b;
      tick();
      cmd = IDLE;
   endtask

   task automatic set_chan(input int c, input logic [31:0] bias, mult, shift);
      do_cmd(7'd1, c, bias);
      do_cmd(7'd2, c, mult);
      do_cmd(7'd3, c, shift);
   endtask

   task automatic send_beat(input logic [127:0] v);
      int   n;
      logic hs;
      in_valid = 1'b1; in_acc = v; n = 0;
      do begin
         @(posedge clk);
         hs = in_ready;
         n++;
      end while (!hs && n < 60);
      #1;
      in_valid = 1'b0;
      if (!hs) begin
         checks++; errors++;
         $display("FAIL send_beat: in_ready=%b, want 1 within 60 cycles", hs);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (ret !== 32'd0) begin errors++; $display("FAIL reset_ret: got %h want 0", ret); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      rst_n = 1'b1;
      tick();
      do_cmd(7'd8, 0, 0);
      checks++;
      if (ret !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", ret); end
   endtask

   task automatic test_latency();
      for (int c = 0; c < 4; c++) set_chan(c, 0, M30, 0);
      do_cmd(7'd6, 0, -32'sd128);
      send_beat(pk(100, 100, 100, 100));
      repeat (2) tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid=%b want 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hB2B2B2B2) begin
         errors++;
         $display("FAIL latency_4: out_valid=%b out_data=%h want 1/b2b2b2b2", out_valid, out_data);
      end
      tick();
   endtask

   task automatic test_arith();
      logic [127:0] acc_v [3];
      logic [31:0]  exp_v [3];
      int n;
      acc_v[0] = pk(-100, 100, MIN32, 1000);   exp_v[0] = 32'h7F7F19CE;
      acc_v[1] = pk(-6, 6, 1000, 127);         exp_v[1] = 32'h408002FD;
      acc_v[2] = pk(0, -6, -1000, -3);         exp_v[2] = 32'hFF7FFE00;
      do_cmd(7'd6, 0, 0);
      set_chan(1, 0, M30, -1);
      set_chan(2, 0, MIN32, 0);
      do_cmd(7'd1, 256, 5000);
      for (int k = 0; k < 3; k++) begin
         send_beat(acc_v[k]);
         n = 0;
         while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
            errors++;
            $display("FAIL arith[%0d]: out_valid=%b out_data=%h want 1/%h", k, out_valid, out_data, exp_v[k]);
         end
         tick();
      end
   endtask

   task automatic test_clamp_inverted();
      int n;
      do_cmd(7'd4, 0, 10);
      do_cmd(7'd5, 0, 5);
      send_beat(pk(-100, 100, MIN32, 1000));
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h05050505) begin
         errors++;
         $display("FAIL clamp_inverted: out_valid=%b out_data=%h want 1/05050505", out_valid, out_data);
      end
      tick();
      do_cmd(7'd4, 0, -32'sd128);
      do_cmd(7'd5, 0, 127);
   endtask

   task automatic test_channels();
      logic [31:0] exp_v [3];
      int n;
      exp_v[0] = 32'h02010100;
      exp_v[1] = 32'h04030302;
      exp_v[2] = 32'h02010100;
      do_cmd(7'd7, 0, 8);
      for (int c = 0; c < 8; c++) set_chan(c, c, M30, 0);
      do_cmd(7'd0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         send_beat(pk(0, 0, 0, 0));
         n = 0;
         while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
            errors++;
            $display("FAIL channels[%0d]: out_valid=%b out_data=%h want 1/%h", k, out_valid, out_data, exp_v[k]);
         end
         tick();
      end
      do_cmd(7'd8, 0, 0);
      checks++;
      if (ret !== 32'd4) begin errors++; $display("FAIL chan_ctr_status: got %h want 00000004", ret); end
   endtask

   task automatic test_stall();
      logic [31:0] exp_v [5];
      exp_v[0] = 32'h02010100;
      exp_v[1] = 32'h08070706;
      exp_v[2] = 32'h0A090908;
      exp_v[3] = 32'h100F0F0E;
      exp_v[4] = 32'h12111110;
      do_cmd(7'd0, 0, 0);
      out_ready = 1'b0;
      fork
         begin : producer
            for (int k = 0; k < 5; k++) send_beat({4{32'(8 * k)}});
         end
         begin : consumer
            int          n;
            logic [31:0] snap;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
            snap = out_data;
            checks++;
            if (out_valid !== 1'b1 || snap !== exp_v[0]) begin
               errors++;
               $display("FAIL stall_first: out_valid=%b out_data=%h want 1/%h", out_valid, snap, exp_v[0]);
            end
            repeat (4) tick();
            do_cmd(7'd1, 0, 100);
            do_cmd(7'd8, 0, 0);
            checks++;
            if (ret[31] !== 1'b1) begin errors++; $display("FAIL status_busy: got %b want 1", ret[31]); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap) begin
               errors++;
               $display("FAIL stall_hold: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, snap);
            end
            out_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
               n = 0;
               while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
               checks++;
               if (out_valid !== 1'b1 || out_data !== exp_v[k]) begin
                  errors++;
                  $display("FAIL stall_beat[%0d]: out_valid=%b out_data=%h want 1/%h", k, out_valid, out_data, exp_v[k]);
               end
               tick();
            end
         end
      join
   endtask

   task automatic test_reset_midflight();
      logic seen;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_beat(pk(0, 0, 0, 0));
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_pre: out_valid=%b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_async: out_valid=%b want 0", out_valid); end
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midflight_stale: out_valid seen=%b want 0", seen); end
      do_cmd(7'd8, 0, 0);
      checks++;
      if (ret !== 32'd0) begin errors++; $display("FAIL midflight_status: got %h want 0", ret); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_arith();
      test_clamp_inverted();
      test_channels();
      test_stall();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
